mole_scheduler: RTL

Game sequencer for the four-mole whack-a-mole board. Runs the IDLE/PLAY/OVER round, launches moles pseudo-randomly on a fixed cadence with a cap on concurrent moles, times each mole, and converts synchronized button presses into hit/miss score updates. Drives the mole lamps, the `ingame` flag and the `score` bus consumed by the LED and VGA display logic.

---
 rtl/mole_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mole_scheduler.sv
// mole_scheduler: round FSM, pseudo-random mole launcher, per-mole timers and hit/miss scoring.
// Optional build macro WHIFF_PENALTY_EN: a press on a button with no raised mole costs one point.
module mole_scheduler #(
  parameter int TICK_DIV   = 100000,
  parameter int UP_TICKS   = 1500,
  parameter int GAP_TICKS  = 700,
  parameter int GAME_TICKS = 30000,
  parameter int MAX_UP     = 2,
  parameter int SCORE_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         btn_n,
  input  logic               start_n,
  output logic [3:0]         mole_up,
  output logic               ingame,
  output logic [SCORE_W-1:0] score,
  output logic [15:0]        time_left,
  output logic               hit_pulse,
  output logic               miss_pulse
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = $clog2(UP_TICKS + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] UP_INIT   = TW'(UP_TICKS);
  localparam logic [GW-1:0] GAP_INIT  = GW'(GAP_TICKS);
  localparam logic [15:0]   GAME_INIT = 16'(GAME_TICKS);
  localparam logic [2:0]    MAX_CNT   = 3'(MAX_UP);
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;
  localparam logic [15:0]   LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  function automatic logic [SCORE_W-1:0] sat_update(input logic [SCORE_W-1:0] cur,
                                                    input logic [2:0] gain,
                                                    input logic [3:0] loss);
    logic [SCORE_W+3:0] acc;
    acc = {4'b0000, cur} + (SCORE_W+4)'(gain);
    if (acc < (SCORE_W+4)'(loss)) return '0;
    acc = acc - (SCORE_W+4)'(loss);
    if (acc[SCORE_W+3:SCORE_W] != 4'b0000) return '1;
    return acc[SCORE_W-1:0];
  endfunction

  // Input conditioning for {start, btn[3:0]}: 2-FF sync, then registered falling-edge strobe.
  logic [4:0] sync1_q, sync2_q, last_q, press_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      last_q  <= '1;
      press_q <= '0;
    end else begin
      sync1_q <= {start_n, btn_n};
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      press_q <= last_q & ~sync2_q;
    end
  end

  state_t             state_q;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [PW-1:0]      pre_q;
  logic [GW-1:0]      launch_q;
  logic [TW-1:0]      tmr_q [4];
  logic [3:0]         mole_q;
  logic               ingame_q, hit_q, miss_q;
  logic [SCORE_W-1:0] score_q;
  logic [15:0]        time_q;

  logic       tick, do_launch, found;
  logic [3:0] hit, miss, whiff;
  logic [1:0] pick, cand;
  logic [2:0] up_cnt, n_hit;
  logic [3:0] n_loss;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    tick   = (state_q == PLAY) && (pre_q == PRE_MAX);
    hit    = '0;
    miss   = '0;
    whiff  = '0;
    up_cnt = '0;
    n_hit  = '0;
    n_loss = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i]  = (state_q == PLAY) && press_q[i] && mole_q[i];
      miss[i] = tick && mole_q[i] && (tmr_q[i] == TW'(1)) && !hit[i];
`ifdef WHIFF_PENALTY_EN
      whiff[i] = (state_q == PLAY) && press_q[i] && !mole_q[i];
`endif
      up_cnt = up_cnt + 3'(mole_q[i]);
      n_hit  = n_hit + 3'(hit[i]);
      n_loss = n_loss + 4'(miss[i]) + 4'(whiff[i]);
    end
    // Candidate search works on registered lamps, so a mole dropping this cycle is not reused.
    pick  = lfsr_q[1:0];
    cand  = lfsr_q[1:0];
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = lfsr_q[1:0] + 2'(k);
      if (!found && !mole_q[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    do_launch = tick && (launch_q == GW'(1)) && (up_cnt < MAX_CNT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_SEED;
      pre_q    <= '0;
      launch_q <= '0;
      tmr_q    <= '{default: '0};
      mole_q   <= '0;
      ingame_q <= 1'b0;
      score_q  <= '0;
      time_q   <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        PLAY: begin
          pre_q <= tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            time_q   <= time_q - 1'b1;
            launch_q <= (launch_q == GW'(1)) ? GAP_INIT : launch_q - 1'b1;
          end
          for (int i = 0; i < 4; i++) begin
            if (hit[i] || miss[i]) mole_q[i] <= 1'b0;
            else if (tick && mole_q[i]) tmr_q[i] <= tmr_q[i] - 1'b1;
          end
          if (do_launch) begin
            mole_q[pick] <= 1'b1;
            tmr_q[pick]  <= UP_INIT;
          end
          score_q <= sat_update(score_q, n_hit, n_loss);
          hit_q   <= |hit;
          miss_q  <= |miss;
          // Final tick: this cycle's events still score, but every lamp goes dark.
          if (tick && (time_q == 16'd1)) begin
            state_q  <= OVER;
            ingame_q <= 1'b0;
            mole_q   <= '0;
          end
        end
        default: begin
          if (press_q[4]) begin
            state_q  <= PLAY;
            ingame_q <= 1'b1;
            score_q  <= '0;
            time_q   <= GAME_INIT;
            mole_q   <= '0;
            launch_q <= GAP_INIT;
            pre_q    <= '0;
          end
        end
      endcase
    end
  end

  assign mole_up    = mole_q;
  assign ingame     = ingame_q;
  assign score      = score_q;
  assign time_left  = time_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
endmodule
